// File: rtl/pc_fetch_ctrl_if.sv
// Handshake and datapath-control bundle between the fetch controller and
// the PC/MAR/MDR/IR registers, memory read port and execute unit.
interface pc_fetch_ctrl_if;
  logic        run;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        pc_en;
  logic        mar_load;
  logic [31:0] mar_addr;
  logic        mem_rd;
  logic        mem_rdy;
  logic        mdr_load;
  logic        ir_load;
  logic        exec_start;
  logic        exec_done;
  logic        br_taken;
  logic [31:0] br_target;
  logic        halt_req;
  logic        fault;
  logic [2:0]  state;
  logic [31:0] instr_count;

  modport master (
    input  run, pc_q, mem_rdy, exec_done, br_taken, br_target, halt_req,
    output pc_d, pc_en, mar_load, mar_addr, mem_rd, mdr_load, ir_load,
           exec_start, fault, state, instr_count
  );

  modport slave (
    output run, pc_q, mem_rdy, exec_done, br_taken, br_target, halt_req,
    input  pc_d, pc_en, mar_load, mar_addr, mem_rd, mdr_load, ir_load,
           exec_start, fault, state, instr_count
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch/sequence controller: drives PC/MAR/MDR/IR enables through the fetch
// phase, hands off to the execute unit and applies branch redirects.
module pc_fetch_ctrl #(
  parameter logic [31:0] PC_INC  = 32'd1,
  parameter int          TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           clr,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH0 = 3'd1,
    FETCH1 = 3'd2,
    FETCH2 = 3'd3,
    EXEC   = 3'd4,
    HALTED = 3'd5,
    FAULT  = 3'd6
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_n;
  logic [7:0]  cnt_q, cnt_n;
  logic [31:0] count_q, count_n;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      count_q <= count_n;
    end
  end

  // The timeout counter doubles as the "first EXEC cycle" marker: it is zeroed
  // in FETCH2 and set once EXEC has been occupied, gating exec_start.
  always_comb begin
    state_n         = state_q;
    cnt_n           = cnt_q;
    count_n         = count_q;
    bus.pc_d        = bus.pc_q + PC_INC;
    bus.pc_en       = 1'b0;
    bus.mar_load    = 1'b0;
    bus.mem_rd      = 1'b0;
    bus.mdr_load    = 1'b0;
    bus.ir_load     = 1'b0;
    bus.exec_start  = 1'b0;
    bus.fault       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.run) state_n = FETCH0;
      end
      FETCH0: begin
        bus.mar_load = 1'b1;
        cnt_n        = 8'd0;
        state_n      = FETCH1;
      end
      FETCH1: begin
        bus.mem_rd = 1'b1;
        if (bus.mem_rdy) begin
          bus.mdr_load = 1'b1;
          bus.pc_en    = 1'b1;
          state_n      = FETCH2;
        end else if (cnt_q == TMO_LAST) begin
          state_n = FAULT;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      FETCH2: begin
        bus.ir_load = 1'b1;
        cnt_n       = 8'd0;
        state_n     = EXEC;
      end
      EXEC: begin
        bus.exec_start = (cnt_q == 8'd0);
        cnt_n          = 8'd1;
        if (bus.exec_done) begin
          count_n = count_q + 32'd1;
          if (bus.halt_req) begin
            state_n = HALTED;
          end else begin
            if (bus.br_taken) begin
              bus.pc_en = 1'b1;
              bus.pc_d  = bus.br_target;
            end
            state_n = bus.run ? FETCH0 : IDLE;
          end
        end
      end
      HALTED: state_n = HALTED;
      FAULT: begin
        bus.fault = 1'b1;
        state_n   = FAULT;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.mar_addr    = bus.pc_q;
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: inputs change on the falling edge and
// outputs are compared 1 time unit later, well away from the rising edge.
module tb_pc_fetch_ctrl;

  logic clk;
  logic clr;
  int   vectors;
  int   miscompares;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl #(.PC_INC(32'd1), .TIMEOUT(16)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    clr           = 1'b0;
    bus.run       = 1'b0;
    bus.pc_q      = 32'h5;
    bus.mem_rdy   = 1'b0;
    bus.exec_done = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = 32'h0;
    bus.halt_req  = 1'b0;

    #2;
    checkOutput("rst_state", 32'(bus.state), 32'd0);
    checkOutput("rst_count", bus.instr_count, 32'd0);
    checkOutput("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    checkOutput("rst_fault", 32'(bus.fault), 32'd0);
    checkOutput("rst_pc_en", 32'(bus.pc_en), 32'd0);
    checkOutput("rst_pc_d", bus.pc_d, 32'h6);

    // Normal fetch from 0x10, data on third FETCH1 cycle
    applyStimulus(1); clr = 1'b1; bus.pc_q = 32'h10; bus.run = 1'b1; #1;
    checkOutput("nf_idle", 32'(bus.state), 32'd0);
    applyStimulus(1); #1;
    checkOutput("nf_f0_state", 32'(bus.state), 32'd1);
    checkOutput("nf_mar_load", 32'(bus.mar_load), 32'd1);
    checkOutput("nf_mar_addr", bus.mar_addr, 32'h10);
    checkOutput("nf_f0_pc_en", 32'(bus.pc_en), 32'd0);
    applyStimulus(1); #1;
    checkOutput("nf_f1_state", 32'(bus.state), 32'd2);
    checkOutput("nf_f1_mem_rd", 32'(bus.mem_rd), 32'd1);
    checkOutput("nf_f1_pc_en", 32'(bus.pc_en), 32'd0);
    checkOutput("nf_f1_mdr", 32'(bus.mdr_load), 32'd0);
    applyStimulus(1); #1;
    checkOutput("nf_f1c2_mem_rd", 32'(bus.mem_rd), 32'd1);
    applyStimulus(1); bus.mem_rdy = 1'b1; #1;
    checkOutput("nf_pc_en", 32'(bus.pc_en), 32'd1);
    checkOutput("nf_pc_d", bus.pc_d, 32'h11);
    checkOutput("nf_mdr_load", 32'(bus.mdr_load), 32'd1);
    applyStimulus(1); bus.mem_rdy = 1'b0; bus.pc_q = 32'h11; #1;
    checkOutput("nf_f2_state", 32'(bus.state), 32'd3);
    checkOutput("nf_ir_load", 32'(bus.ir_load), 32'd1);
    checkOutput("nf_f2_pc_en", 32'(bus.pc_en), 32'd0);
    applyStimulus(1); #1;
    checkOutput("nf_exec_state", 32'(bus.state), 32'd4);
    checkOutput("nf_exec_start", 32'(bus.exec_start), 32'd1);
    applyStimulus(1); #1;
    checkOutput("nf_exec_start2", 32'(bus.exec_start), 32'd0);
    checkOutput("nf_exec_hold", 32'(bus.state), 32'd4);
    applyStimulus(1); bus.exec_done = 1'b1; #1;
    checkOutput("nf_done_pc_en", 32'(bus.pc_en), 32'd0);
    checkOutput("nf_done_count", bus.instr_count, 32'd0);
    applyStimulus(1); bus.exec_done = 1'b0; #1;
    checkOutput("nf_back_f0", 32'(bus.state), 32'd1);
    checkOutput("nf_count1", bus.instr_count, 32'd1);

    // Branch with single-cycle execute
    applyStimulus(1); bus.mem_rdy = 1'b1; #1;
    checkOutput("br_f1_pc_d", bus.pc_d, 32'h12);
    applyStimulus(1); bus.mem_rdy = 1'b0; bus.pc_q = 32'h12; #1;
    checkOutput("br_ir_load", 32'(bus.ir_load), 32'd1);
    applyStimulus(1);
    bus.exec_done = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h40; #1;
    checkOutput("br_exec_start", 32'(bus.exec_start), 32'd1);
    checkOutput("br_pc_en", 32'(bus.pc_en), 32'd1);
    checkOutput("br_pc_d", bus.pc_d, 32'h40);
    applyStimulus(1);
    bus.exec_done = 1'b0; bus.br_taken = 1'b0; bus.pc_q = 32'h40; #1;
    checkOutput("br_f0", 32'(bus.state), 32'd1);
    checkOutput("br_count2", bus.instr_count, 32'd2);
    checkOutput("br_mar_addr", bus.mar_addr, 32'h40);

    // Stop at the instruction boundary, then restart
    applyStimulus(1); bus.mem_rdy = 1'b1;
    applyStimulus(1); bus.mem_rdy = 1'b0; bus.pc_q = 32'h41;
    applyStimulus(1); bus.exec_done = 1'b1; bus.run = 1'b0; #1;
    checkOutput("stop_exec", 32'(bus.state), 32'd4);
    applyStimulus(1); bus.exec_done = 1'b0; #1;
    checkOutput("stop_idle", 32'(bus.state), 32'd0);
    checkOutput("stop_count3", bus.instr_count, 32'd3);
    checkOutput("stop_mar0", 32'(bus.mar_load), 32'd0);
    applyStimulus(1); #1;
    checkOutput("stop_idle2", 32'(bus.state), 32'd0);
    checkOutput("stop_mar1", 32'(bus.mar_load), 32'd0);
    bus.run = 1'b1; bus.pc_q = 32'hFFFF_FFFF;
    applyStimulus(1); #1;
    checkOutput("restart_f0", 32'(bus.state), 32'd1);

    // PC wrap, then halt beats branch
    applyStimulus(1); bus.mem_rdy = 1'b1; #1;
    checkOutput("wrap_pc_en", 32'(bus.pc_en), 32'd1);
    checkOutput("wrap_pc_d", bus.pc_d, 32'h0);
    applyStimulus(1); bus.mem_rdy = 1'b0; bus.pc_q = 32'h0;
    applyStimulus(1);
    bus.exec_done = 1'b1; bus.halt_req = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h80; #1;
    checkOutput("halt_pc_en", 32'(bus.pc_en), 32'd0);
    checkOutput("halt_pc_d", bus.pc_d, 32'h1);
    applyStimulus(1); bus.halt_req = 1'b0; bus.br_taken = 1'b0; #1;
    checkOutput("halt_state", 32'(bus.state), 32'd5);
    checkOutput("halt_count4", bus.instr_count, 32'd4);
    applyStimulus(1); bus.exec_done = 1'b0; #1;
    checkOutput("halt_hold", 32'(bus.state), 32'd5);
    checkOutput("halt_ign_done", bus.instr_count, 32'd4);
    checkOutput("halt_mar", 32'(bus.mar_load), 32'd0);
    checkOutput("halt_mem_rd", 32'(bus.mem_rd), 32'd0);

    // Asynchronous reset in the middle of FETCH1
    applyStimulus(1); clr = 1'b0;
    applyStimulus(1); clr = 1'b1; bus.pc_q = 32'h20;
    applyStimulus(1); #1;
    checkOutput("rmf_f0", 32'(bus.state), 32'd1);
    applyStimulus(1); #1;
    checkOutput("rmf_mem_rd_before", 32'(bus.mem_rd), 32'd1);
    #2; clr = 1'b0; #1;
    checkOutput("rmf_state", 32'(bus.state), 32'd0);
    checkOutput("rmf_mem_rd", 32'(bus.mem_rd), 32'd0);
    checkOutput("rmf_pc_en", 32'(bus.pc_en), 32'd0);
    checkOutput("rmf_count", bus.instr_count, 32'd0);

    // Timeout: 16 FETCH1 cycles with no data
    applyStimulus(1); clr = 1'b1;
    applyStimulus(1); #1;
    checkOutput("to_f0", 32'(bus.state), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1); #1;
      checkOutput($sformatf("to_f1_cyc%0d", i), 32'(bus.state), 32'd2);
    end
    applyStimulus(1); #1;
    checkOutput("to_fault_state", 32'(bus.state), 32'd6);
    checkOutput("to_fault_flag", 32'(bus.fault), 32'd1);
    applyStimulus(1); #1;
    checkOutput("to_fault_hold", 32'(bus.state), 32'd6);
    checkOutput("to_fault_mem_rd", 32'(bus.mem_rd), 32'd0);

    // Data arriving on the last permitted FETCH1 cycle
    applyStimulus(1); clr = 1'b0;
    applyStimulus(1); clr = 1'b1;
    applyStimulus(1); #1;
    checkOutput("to2_f0", 32'(bus.state), 32'd1);
    applyStimulus(15);
    applyStimulus(1); bus.mem_rdy = 1'b1; #1;
    checkOutput("to2_cyc16_state", 32'(bus.state), 32'd2);
    checkOutput("to2_cyc16_pc_en", 32'(bus.pc_en), 32'd1);
    applyStimulus(1); bus.mem_rdy = 1'b0; #1;
    checkOutput("to2_f2", 32'(bus.state), 32'd3);
    checkOutput("to2_no_fault", 32'(bus.fault), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
